// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register addresses and enables in, stall/flush/forward controls out.
// Latency: none, this is wiring only.
// Backpressure: pc_stop holds the front end and id_ex_bubble/if_id_flush squash slots; there is no valid/ready pair.
interface hazard_ctrl_if;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rs1_addr;
    logic [4:0] ex_rs2_addr;
    logic [4:0] ex_rd_addr;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] mem_rd_addr;
    logic       mem_reg_write;
    logic [4:0] wb_rd_addr;
    logic       wb_reg_write;
    logic       ex_branch_taken;
    logic       ex_muldiv_start;
    logic       muldiv_done;
    logic       pc_stop;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       md_timeout;
    logic [1:0] hz_state;

    // Pipeline side: presents stage state, consumes hazard controls.
    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read,
        output mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write,
        output ex_branch_taken, ex_muldiv_start, muldiv_done,
        input  pc_stop, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
        input  md_timeout, hz_state
    );

    // Hazard controller side.
    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read,
        input  mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write,
        input  ex_branch_taken, ex_muldiv_start, muldiv_done,
        output pc_stop, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
        output md_timeout, hz_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use / RAW stalls, branch flush, mul/div wait, operand forwarding.
// Latency: stall, flush and forward selects are combinational in the detecting cycle; FSM adds one registered follow-up cycle.
// Backpressure: pc_stop freezes PC, IF/ID and ID/EX; mul/div wait holds until muldiv_done or MULDIV_MAX_CYCLES timeout.
// Build option: define HAZARD_FWD_EN to enable forwarding; without it every EX/MEM RAW match stalls instead.
module hazard_ctrl #(
    parameter int MULDIV_MAX_CYCLES = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MD_WAIT    = 2'b10,
        FLUSH      = 2'b11
    } state_t;

    // Counter value seen in the last permitted wait cycle.
    localparam logic [5:0] MD_LAST = 6'(MULDIV_MAX_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] md_cnt;
    logic       md_timeout;
    logic       md_expire;

    logic       ex_match;
    logic       raw_stall;
    logic       ls_hold;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    logic       pc_stop;
    logic       if_id_flush;
    logic       id_ex_bubble;

    // A used ID source equal to a non-zero destination; x0 never matches.
    function automatic logic id_reads(input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic rs1_used,
                                      input logic [4:0] rs2, input logic rs2_used);
        return (rd != 5'd0) && ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

    assign ex_match = id_reads(bus.ex_rd_addr, bus.id_rs1_addr, bus.id_rs1_used,
                               bus.id_rs2_addr, bus.id_rs2_used);

`ifdef HAZARD_FWD_EN
    // Forward source for one EX operand; the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                            input logic [4:0] mem_rd, input logic mem_we,
                                            input logic [4:0] wb_rd,  input logic wb_we);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src))
            sel = 2'b01;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
            sel = 2'b10;
        return sel;
    endfunction

    // Only a load in EX is too late to forward; everything else is bypassed.
    assign raw_stall = ex_match && bus.ex_reg_write && bus.ex_mem_read;
    // The load reaches MEM after exactly one stall cycle, so that cycle always holds.
    assign ls_hold   = 1'b1;
    assign fwd_a     = fwd_pick(bus.ex_rs1_addr, bus.mem_rd_addr, bus.mem_reg_write,
                                bus.wb_rd_addr, bus.wb_reg_write);
    assign fwd_b     = fwd_pick(bus.ex_rs2_addr, bus.mem_rd_addr, bus.mem_reg_write,
                                bus.wb_rd_addr, bus.wb_reg_write);
`else
    logic mem_match;
    logic unused_no_fwd;

    assign mem_match = id_reads(bus.mem_rd_addr, bus.id_rs1_addr, bus.id_rs1_used,
                                bus.id_rs2_addr, bus.id_rs2_used);
    // No bypass network: any pending EX or MEM writer of an ID source stalls.
    // WB needs no stall because the register file is write-first.
    assign raw_stall = (ex_match && bus.ex_reg_write) || (mem_match && bus.mem_reg_write);
    // The stall cycle keeps holding only while a writer is still in flight.
    assign ls_hold   = raw_stall;
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
    assign unused_no_fwd = ^{bus.ex_rs1_addr, bus.ex_rs2_addr, bus.wb_rd_addr, bus.wb_reg_write};
`endif

    // Wait cycles exhausted with no completion seen.
    assign md_expire = (state == MD_WAIT) && !bus.muldiv_done && (md_cnt == MD_LAST);

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            md_cnt     <= 6'd0;
            md_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == MD_WAIT) && (state_nxt == MD_WAIT))
                md_cnt <= md_cnt + 6'd1;
            else
                md_cnt <= 6'd0;
            if (md_expire)
                md_timeout <= 1'b1;
        end
    end

    // Next state: branch beats mul/div beats load-use in RUN; the other states are fixed-length or wait-bound.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (bus.ex_branch_taken)
                    state_nxt = FLUSH;
                else if (bus.ex_muldiv_start)
                    state_nxt = MD_WAIT;
                else if (raw_stall)
                    state_nxt = LOAD_STALL;
                else
                    state_nxt = RUN;
            end
            LOAD_STALL: state_nxt = RUN;
            MD_WAIT: begin
                if (bus.muldiv_done || md_expire)
                    state_nxt = RUN;
                else
                    state_nxt = MD_WAIT;
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Pipeline controls; everything is forced low while reset is held.
    always_comb begin
        pc_stop      = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    // Redirect wins over a simultaneous load-use: squash, do not hold.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (bus.ex_muldiv_start) begin
                    pc_stop      = 1'b0;
                end else if (raw_stall) begin
                    pc_stop      = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
            LOAD_STALL: begin
                pc_stop      = ls_hold;
                id_ex_bubble = ls_hold;
            end
            MD_WAIT: begin
                // Release in the same cycle completion is reported.
                pc_stop = !bus.muldiv_done;
            end
            FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            default: begin
                pc_stop = 1'b0;
            end
        endcase
        if (!rst_n) begin
            pc_stop      = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
        end
    end

    assign bus.pc_stop      = pc_stop;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.fwd_a_sel    = rst_n ? fwd_a : 2'b00;
    assign bus.fwd_b_sel    = rst_n ? fwd_b : 2'b00;
    assign bus.md_timeout   = md_timeout;
    assign bus.hz_state     = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, forwarding priority, RAW stall, mul/div wait and timeout,
// branch vs load-use, reset during a wait. Expected values are hand-derived; forwarding expectations
// follow whether HAZARD_FWD_EN is defined for the build.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   stalls;

    hazard_ctrl_if bus();

    hazard_ctrl #(.MULDIV_MAX_CYCLES(34)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.id_rs1_addr     = 5'd0;
        bus.id_rs2_addr     = 5'd0;
        bus.id_rs1_used     = 1'b0;
        bus.id_rs2_used     = 1'b0;
        bus.ex_rs1_addr     = 5'd0;
        bus.ex_rs2_addr     = 5'd0;
        bus.ex_rd_addr      = 5'd0;
        bus.ex_reg_write    = 1'b0;
        bus.ex_mem_read     = 1'b0;
        bus.mem_rd_addr     = 5'd0;
        bus.mem_reg_write   = 1'b0;
        bus.wb_rd_addr      = 5'd0;
        bus.wb_reg_write    = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.ex_muldiv_start = 1'b0;
        bus.muldiv_done     = 1'b0;
    endtask

    task automatic load_use_x5();
        bus.ex_mem_read  = 1'b1;
        bus.ex_reg_write = 1'b1;
        bus.ex_rd_addr   = 5'd5;
        bus.id_rs1_addr  = 5'd5;
        bus.id_rs1_used  = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stalls = 0;
        rst_n  = 1'b0;
        clear_in();

        // Reset holds everything low even with hazard and forward inputs present.
        #12;
        load_use_x5();
        bus.ex_rs1_addr   = 5'd5;
        bus.mem_rd_addr   = 5'd5;
        bus.mem_reg_write = 1'b1;
        #1;
        check("rst_pc_stop", 8'(bus.pc_stop), 8'd0);
        check("rst_bubble",  8'(bus.id_ex_bubble), 8'd0);
        check("rst_flush",   8'(bus.if_id_flush), 8'd0);
        check("rst_state",   8'(bus.hz_state), 8'd0);
        check("rst_timeout", 8'(bus.md_timeout), 8'd0);
        check("rst_fwd_a",   8'(bus.fwd_a_sel), 8'd0);
        clear_in();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Load to x5 in EX, consumer of x5 in ID.
        load_use_x5();
        #1;
        check("lu_det_pc_stop", 8'(bus.pc_stop), 8'd1);
        check("lu_det_bubble",  8'(bus.id_ex_bubble), 8'd1);
        check("lu_det_flush",   8'(bus.if_id_flush), 8'd0);
        check("lu_det_state",   8'(bus.hz_state), 8'd0);
        cyc();
        bus.ex_mem_read   = 1'b0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_rd_addr    = 5'd0;
        bus.mem_rd_addr   = 5'd5;
        bus.mem_reg_write = 1'b1;
        #1;
        check("lu_stall_state",   8'(bus.hz_state), 8'd1);
        check("lu_stall_pc_stop", 8'(bus.pc_stop), 8'd1);
        check("lu_stall_bubble",  8'(bus.id_ex_bubble), 8'd1);
        cyc();
        bus.id_rs1_addr = 5'd0;
        bus.id_rs1_used = 1'b0;
        bus.ex_rs1_addr = 5'd5;
        #1;
        check("lu_after_state",   8'(bus.hz_state), 8'd0);
        check("lu_after_pc_stop", 8'(bus.pc_stop), 8'd0);
        check("lu_after_bubble",  8'(bus.id_ex_bubble), 8'd0);
        check("lu_after_fwd_a",   8'(bus.fwd_a_sel), 8'(FWD ? 2'b01 : 2'b00));

        // Forwarding priority on operand B, then WB-only on operand A.
        clear_in();
        bus.ex_rs2_addr   = 5'd7;
        bus.mem_rd_addr   = 5'd7;
        bus.wb_rd_addr    = 5'd7;
        bus.mem_reg_write = 1'b1;
        bus.wb_reg_write  = 1'b1;
        #1;
        check("fwd_b_mem_wins", 8'(bus.fwd_b_sel), 8'(FWD ? 2'b01 : 2'b00));
        bus.mem_reg_write = 1'b0;
        #1;
        check("fwd_b_wb", 8'(bus.fwd_b_sel), 8'(FWD ? 2'b10 : 2'b00));
        bus.mem_reg_write = 1'b1;
        bus.ex_rs2_addr   = 5'd0;
        bus.mem_rd_addr   = 5'd0;
        bus.wb_rd_addr    = 5'd0;
        #1;
        check("fwd_b_x0", 8'(bus.fwd_b_sel), 8'd0);
        bus.ex_rs1_addr = 5'd3;
        bus.wb_rd_addr  = 5'd3;
        #1;
        check("fwd_a_wb", 8'(bus.fwd_a_sel), 8'(FWD ? 2'b10 : 2'b00));
        check("fwd_no_stall", 8'(bus.pc_stop), 8'd0);

        // A load targeting x0 never stalls.
        clear_in();
        bus.ex_mem_read  = 1'b1;
        bus.ex_reg_write = 1'b1;
        bus.id_rs1_used  = 1'b1;
        #1;
        check("x0_load_pc_stop", 8'(bus.pc_stop), 8'd0);

        // ALU writer of x9 in EX, x9 read in ID: stall only without forwarding.
        clear_in();
        bus.ex_reg_write = 1'b1;
        bus.ex_rd_addr   = 5'd9;
        bus.id_rs2_addr  = 5'd9;
        bus.id_rs2_used  = 1'b1;
        #1;
        check("alu_raw_pc_stop", 8'(bus.pc_stop), 8'(!FWD));
        check("alu_raw_bubble",  8'(bus.id_ex_bubble), 8'(!FWD));
        cyc();
        #1;
        check("alu_raw_state", 8'(bus.hz_state), 8'(FWD ? 2'b00 : 2'b01));
        clear_in();
        cyc();
        #1;
        check("alu_raw_back_run", 8'(bus.hz_state), 8'd0);

        // Mul/div start, ten wait cycles (branch ignored), then completion.
        clear_in();
        bus.ex_muldiv_start = 1'b1;
        #1;
        check("md_start_pc_stop", 8'(bus.pc_stop), 8'd0);
        check("md_start_state",   8'(bus.hz_state), 8'd0);
        cyc();
        bus.ex_muldiv_start = 1'b0;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            bus.ex_branch_taken = (i == 3);
            #1;
            if (bus.pc_stop === 1'b1) stalls++;
            check("md_wait_state", 8'(bus.hz_state), 8'd2);
            check("md_wait_flush", 8'(bus.if_id_flush), 8'd0);
            cyc();
        end
        bus.ex_branch_taken = 1'b0;
        bus.muldiv_done     = 1'b1;
        #1;
        if (bus.pc_stop === 1'b1) stalls++;
        check("md_done_pc_stop", 8'(bus.pc_stop), 8'd0);
        check("md_done_state",   8'(bus.hz_state), 8'd2);
        check("md_stall_cycles", 8'(stalls), 8'd10);
        cyc();
        bus.muldiv_done = 1'b0;
        #1;
        check("md_end_state",   8'(bus.hz_state), 8'd0);
        check("md_end_timeout", 8'(bus.md_timeout), 8'd0);

        // Branch and load-use together: flush wins, no hold.
        load_use_x5();
        bus.ex_branch_taken = 1'b1;
        #1;
        check("br_flush",   8'(bus.if_id_flush), 8'd1);
        check("br_bubble",  8'(bus.id_ex_bubble), 8'd1);
        check("br_pc_stop", 8'(bus.pc_stop), 8'd0);
        check("br_state",   8'(bus.hz_state), 8'd0);
        cyc();
        clear_in();
        bus.ex_muldiv_start = 1'b1;
        #1;
        check("flush_state",   8'(bus.hz_state), 8'd3);
        check("flush_flush",   8'(bus.if_id_flush), 8'd1);
        check("flush_bubble",  8'(bus.id_ex_bubble), 8'd1);
        check("flush_pc_stop", 8'(bus.pc_stop), 8'd0);
        cyc();
        bus.ex_muldiv_start = 1'b0;
        #1;
        check("post_flush_state", 8'(bus.hz_state), 8'd0);
        check("post_flush_flush", 8'(bus.if_id_flush), 8'd0);

        // Timeout after 34 wait cycles without completion.
        bus.ex_muldiv_start = 1'b1;
        cyc();
        bus.ex_muldiv_start = 1'b0;
        stalls = 0;
        for (int i = 0; i < 33; i++) begin
            #1;
            if (bus.pc_stop === 1'b1) stalls++;
            cyc();
        end
        #1;
        check("to_stalls_33",  8'(stalls), 8'd33);
        check("to_not_yet",    8'(bus.md_timeout), 8'd0);
        check("to_last_stop",  8'(bus.pc_stop), 8'd1);
        check("to_last_state", 8'(bus.hz_state), 8'd2);
        cyc();
        #1;
        check("to_set",     8'(bus.md_timeout), 8'd1);
        check("to_state",   8'(bus.hz_state), 8'd0);
        check("to_pc_stop", 8'(bus.pc_stop), 8'd0);

        // Timeout stays set through a later, normal mul/div.
        bus.ex_muldiv_start = 1'b1;
        cyc();
        bus.ex_muldiv_start = 1'b0;
        bus.muldiv_done     = 1'b1;
        cyc();
        bus.muldiv_done = 1'b0;
        cyc();
        #1;
        check("to_sticky",       8'(bus.md_timeout), 8'd1);
        check("to_sticky_state", 8'(bus.hz_state), 8'd0);

        // Reset during a mul/div wait.
        bus.ex_muldiv_start = 1'b1;
        cyc();
        bus.ex_muldiv_start = 1'b0;
        cyc();
        #1;
        check("mid_wait_state",   8'(bus.hz_state), 8'd2);
        check("mid_wait_pc_stop", 8'(bus.pc_stop), 8'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state",   8'(bus.hz_state), 8'd0);
        check("mid_rst_pc_stop", 8'(bus.pc_stop), 8'd0);
        check("mid_rst_flush",   8'(bus.if_id_flush), 8'd0);
        check("mid_rst_bubble",  8'(bus.id_ex_bubble), 8'd0);
        check("mid_rst_timeout", 8'(bus.md_timeout), 8'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        check("post_rst_pc_stop", 8'(bus.pc_stop), 8'd0);
        check("post_rst_state",   8'(bus.hz_state), 8'd0);
        cyc();
        #1;
        check("post_rst_idle", 8'(bus.pc_stop), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_MAX_CYCLES, default 34: maximum number of mul/div stall cycles before timeout.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports id_rs1_addr and id_rs2_addr, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have ports id_rs1_used and id_rs2_used, input, 1 bit each: the matching source is read.
REQ-006 SHALL have ports ex_rs1_addr and ex_rs2_addr, input, 5 bits each: source addresses held in the ID/EX register.
REQ-007 SHALL have ports ex_rd_addr (input, 5 bits), ex_reg_write (input, 1 bit) and ex_mem_read (input, 1 bit): destination, write-enable and load flag of the instruction in EX.
REQ-008 SHALL have ports mem_rd_addr (input, 5 bits) and mem_reg_write (input, 1 bit): destination and write-enable of the instruction in MEM.
REQ-009 SHALL have ports wb_rd_addr (input, 5 bits) and wb_reg_write (input, 1 bit): destination and write-enable of the instruction in WB.
REQ-010 SHALL have ports ex_branch_taken, ex_muldiv_start and muldiv_done, input, 1 bit each: redirect, multi-cycle op issue, and multi-cycle op completion.
REQ-011 SHALL have port pc_stop, output, 1 bit: hold PC and IF/ID, and hold ID/EX.
REQ-012 SHALL have ports if_id_flush and id_ex_bubble, output, 1 bit each: squash IF/ID, and load a NOP into ID/EX.
REQ-013 SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 bits each: operand source, where 00 = register file, 01 = EX/MEM result, 10 = WB result.
REQ-014 SHALL have ports md_timeout (output, 1 bit, sticky error) and hz_state (output, 2 bits, current FSM state).

Function
REQ-015 SHALL implement FSM states RUN=00, LOAD_STALL=01, MD_WAIT=10, FLUSH=11.
REQ-016 SHALL define load-use as: ex_mem_read, ex_reg_write, ex_rd_addr != 0, and ex_rd_addr matching a used ID source.
REQ-017 SHALL, in RUN, apply transition priority: ex_branch_taken -> FLUSH; else ex_muldiv_start -> MD_WAIT; else load-use -> LOAD_STALL; else stay in RUN.
REQ-018 SHALL, in RUN, drive pc_stop=1 and id_ex_bubble=1 combinationally in the same cycle as load-use detection.
REQ-019 SHALL, in LOAD_STALL, drive pc_stop=1 and id_ex_bubble=1 for exactly one cycle, then return to RUN; the load result is then forwarded from MEM.
REQ-020 SHALL, in MD_WAIT, hold pc_stop=1 while a 6-bit cycle counter increments; on muldiv_done the FSM returns to RUN, with pc_stop deasserting in the cycle muldiv_done is seen.
REQ-021 SHALL, if the counter reaches MULDIV_MAX_CYCLES without muldiv_done, set md_timeout and return to RUN.
REQ-022 SHALL ignore ex_branch_taken and load-use while in MD_WAIT.
REQ-023 SHALL, in FLUSH, drive if_id_flush=1, id_ex_bubble=1 and pc_stop=0 for one cycle, then return to RUN; ex_muldiv_start in this cycle is ignored.
REQ-024 SHALL drive if_id_flush and id_ex_bubble combinationally in the RUN cycle where ex_branch_taken is seen; ex_branch_taken overrides a simultaneous load-use, so pc_stop=0.
REQ-025 SHALL select forwarding per operand: EX/MEM (01) when mem_reg_write, mem_rd_addr != 0 and mem_rd_addr equals the ex source; else WB (10) under the same rule on the WB stage; else 00.
REQ-026 SHALL give MEM forwarding priority over WB forwarding.
REQ-027 SHALL never forward, stall on, or match register x0.
REQ-028 SHALL keep md_timeout set until reset once it is set.

Reset
REQ-029 SHALL, while rst_n=0, immediately force: state RUN, counter 0, md_timeout 0, pc_stop 0, if_id_flush 0, id_ex_bubble 0, fwd_a_sel 00, fwd_b_sel 00.
REQ-030 SHALL abandon any in-progress stall or flush when reset is asserted mid-operation, with no residual stall after release.

Configuration
REQ-031 SHALL support macro HAZARD_FWD_EN: when defined, forwarding is as in REQ-025.
REQ-032 SHALL, when HAZARD_FWD_EN is undefined, tie fwd_a_sel and fwd_b_sel to 00, and extend load-use detection to any RAW match between used ID sources and EX or MEM writers, with the stall lasting while any match persists.
REQ-033 SHALL, when HAZARD_FWD_EN is undefined, assume WB writes are visible to ID through a write-first register file, so they cause no stall.

Verification
REQ-034 SHALL cover load-use: a load to x5 in EX with id_rs1_addr=5 used gives pc_stop=1 and id_ex_bubble=1 for 2 cycles (detect and LOAD_STALL), then fwd_a_sel=01.
REQ-035 SHALL cover forwarding priority: mem_rd=wb_rd=ex_rs2=7 with both writes enabled gives fwd_b_sel=01; with mem_reg_write=0 it gives 10; with address 0 it gives 00.
REQ-036 SHALL cover mul/div: ex_muldiv_start, then muldiv_done after 10 cycles, gives pc_stop high 10 cycles, then RUN with md_timeout=0.
REQ-037 SHALL cover timeout: with MULDIV_MAX_CYCLES=34 and no muldiv_done, md_timeout=1 after 34 cycles and stays 1 until rst_n pulses low.
REQ-038 SHALL cover branch vs load: branch_taken and load-use in the same cycle give if_id_flush=1, pc_stop=0, then FLUSH for 1 cycle, then RUN.
REQ-039 SHALL cover reset mid-stall: rst_n low during MD_WAIT gives hz_state=00 and all outputs 0 immediately, with no stall after release.
